// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master arbiter and access sequencer for a 256x16 single-port RAM
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   m0_*/m1_* req,we,addr,wdata  level request with operation, address and write data
//   m0_*/m1_* gnt,done     one-cycle pulses marking the start and end of an access
//   m0_*/m1_* rdata        last read result per master, held until its next read completes
//   ram_cs/re/we/addr/data_out  registered RAM control and write data
//   ram_data_in            RAM read data, valid RD_LAT cycles after ram_re first rises
//   busy                   high whenever the sequencer is not idle
module ram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [15:0] m1_rdata,
    output logic        ram_cs,
    output logic        ram_re,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_data_out,
    input  logic [15:0] ram_data_in,
    output logic        busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    logic [1:0] state;
    logic [2:0] cnt;
    logic       last_grant;
    logic       win;
    logic       pick;
    logic       pick_we;
    // On a collision the master that did not win last time goes first.
    always_comb begin
        pick    = (m0_req && m1_req) ? ~last_grant : m1_req;
        pick_we = pick ? m1_we : m0_we;
    end
    // The RAM control registers double as the latched request, so later
    // changes on the master inputs cannot affect an access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            win          <= 1'b0;
            m0_gnt       <= 1'b0;
            m1_gnt       <= 1'b0;
            m0_done      <= 1'b0;
            m1_done      <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            ram_cs       <= 1'b0;
            ram_re       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data_out <= '0;
            busy         <= 1'b0;
        end else begin
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: if (m0_req || m1_req) begin
                    state        <= ACCESS;
                    busy         <= 1'b1;
                    win          <= pick;
                    last_grant   <= pick;
                    m0_gnt       <= ~pick;
                    m1_gnt       <= pick;
                    ram_cs       <= 1'b1;
                    ram_we       <= pick_we;
                    ram_re       <= ~pick_we;
                    ram_addr     <= pick ? m1_addr : m0_addr;
                    ram_data_out <= pick_we ? (pick ? m1_wdata : m0_wdata) : 16'h0;
                end
                ACCESS: begin
                    ram_we       <= 1'b0;
                    ram_data_out <= '0;
                    if (ram_we) begin
                        state   <= DONE;
                        ram_cs  <= 1'b0;
                        m0_done <= ~win;
                        m1_done <= win;
                    end else begin
                        state <= WAIT;
                        cnt   <= 3'(RD_LAT);
                    end
                end
                WAIT: if (cnt == 3'd1) begin
                    state   <= DONE;
                    ram_cs  <= 1'b0;
                    ram_re  <= 1'b0;
                    m0_done <= ~win;
                    m1_done <= win;
                    if (win) m1_rdata <= ram_data_in;
                    else     m0_rdata <= ram_data_in;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
